// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the pipelined ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd13;
    localparam logic [3:0] OP_NOTA = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per cycle.
// Latency: WIDTH cycles after start; done/product are valid during the final iteration cycle.
// Backpressure: none; the owner must not pulse start while an operation is in flight.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int SHW = $clog2(WIDTH);

    logic               busy;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     part_sum;

    // acc holds {partial product high half, remaining multiplier bits}
    always_comb begin
        part_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        product  = {part_sum, acc[WIDTH-1:1]};
        done     = busy && (cnt == SHW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= {{WIDTH{1'b0}}, b_in};
            mcand <= a_in;
        end else if (busy) begin
            acc <= product;
            cnt <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe_nbit.sv
// Handshaked N-bit ALU with registered result, add/sub carry output and {N,V,C,Z} flags.
// Latency: 1 cycle for ops 0-14, WIDTH cycles for MUL (iterative).
// Backpressure: single output register; in_ready drops while a result is stuck or MUL runs.
module alu_pipe_nbit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH:0]   sum_out,
    output logic [3:0]       flags
);
    localparam int SHW = $clog2(WIDTH);

    state_t               state, state_nxt;
    logic                 accept, alu_load, mul_start, mul_done;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH-1:0]     res;
    logic [WIDTH:0]       sum_c, sum_add, sum_sub;
    logic                 c_bit, v_bit;
    logic [3:0]           flg_alu, flg_mul;
    logic [SHW-1:0]       shamt;

    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (sel == OP_MUL);
    assign alu_load  = accept && (sel != OP_MUL);
    assign shamt     = b_in[SHW-1:0];
    assign sum_add   = {1'b0, a_in} + {1'b0, b_in};
    assign sum_sub   = {1'b0, a_in} - {1'b0, b_in};

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a_in    (a_in),
        .b_in    (b_in),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        res   = '0;
        sum_c = '0;
        c_bit = 1'b0;
        v_bit = 1'b0;
        case (sel)
            OP_ADD: begin
                res   = sum_add[WIDTH-1:0];
                sum_c = sum_add;
                c_bit = sum_add[WIDTH];
                v_bit = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sum_sub[WIDTH-1:0];
                sum_c = sum_sub;
                c_bit = sum_sub[WIDTH];
                v_bit = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_AND:  res = a_in & b_in;
            OP_OR:   res = a_in | b_in;
            OP_XOR:  res = a_in ^ b_in;
            OP_NOR:  res = ~(a_in | b_in);
            OP_NAND: res = ~(a_in & b_in);
            OP_XNOR: res = ~(a_in ^ b_in);
            OP_SLL:  res = a_in << shamt;
            OP_SRL:  res = a_in >> shamt;
            OP_SRA:  res = $unsigned($signed(a_in) >>> shamt);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
            OP_PASS: res = a_in;
            OP_NOTA: res = ~a_in;
            default: res = '0;
        endcase
    end

    always_comb begin
        flg_alu        = '0;
        flg_alu[FLG_Z] = (res == '0);
        flg_alu[FLG_N] = res[WIDTH-1];
        flg_alu[FLG_C] = c_bit;
        flg_alu[FLG_V] = v_bit;
        flg_mul        = '0;
        flg_mul[FLG_Z] = (mul_prod[WIDTH-1:0] == '0);
        flg_mul[FLG_N] = mul_prod[WIDTH-1];
        flg_mul[FLG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_MUL;
            ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // A MUL is only accepted when the output is empty or draining, so mul_done never collides with a held result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            y_out     <= '0;
            sum_out   <= '0;
            flags     <= '0;
        end else if (alu_load) begin
            out_valid <= 1'b1;
            y_out     <= res;
            sum_out   <= sum_c;
            flags     <= flg_alu;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            y_out     <= mul_prod[WIDTH-1:0];
            sum_out   <= '0;
            flags     <= flg_mul;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// Directed bench: a vector table on a 32-bit instance plus multi-cycle MUL, backpressure and reset sequences.
module tb_alu_pipe_nbit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid32 = 1'b0, out_ready32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0;
    logic [3:0]  sel32 = '0;
    logic        in_ready32, out_valid32;
    logic [31:0] y32;
    logic [32:0] sum32;
    logic [3:0]  flags32;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  sel8 = '0;
    logic        in_ready8, out_valid8;
    logic [7:0]  y8;
    logic [8:0]  sum8;
    logic [3:0]  flags8;

    alu_pipe_nbit #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a_in(a32), .b_in(b32), .sel(sel32), .out_valid(out_valid32),
        .out_ready(out_ready32), .y_out(y32), .sum_out(sum32), .flags(flags32)
    );

    alu_pipe_nbit #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a_in(a8), .b_in(b8), .sel(sel8), .out_valid(out_valid8),
        .out_ready(out_ready8), .y_out(y8), .sum_out(sum8), .flags(flags8)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [32:0] sum;
        logic [3:0]  flg;   // {N,V,C,Z}
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    initial begin
        int low_cnt;
        int ov_cnt;
        bit seen;

        vecs[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 33'h1_00000000, 4'b0011};
        vecs[1]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 33'h0_7FFFFFFF, 4'b0100};
        vecs[2]  = '{4'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 33'h1_FFFFFFFE, 4'b1010};
        vecs[3]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 33'h0_80000000, 4'b1100};
        vecs[4]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 33'h0, 4'b1000};
        vecs[5]  = '{4'd3,  32'h0000000F, 32'h000000F0, 32'h000000FF, 33'h0, 4'b0000};
        vecs[6]  = '{4'd4,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 33'h0, 4'b0001};
        vecs[7]  = '{4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 33'h0, 4'b1000};
        vecs[8]  = '{4'd6,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33'h0, 4'b0001};
        vecs[9]  = '{4'd7,  32'h12345678, 32'h12345678, 32'hFFFFFFFF, 33'h0, 4'b1000};
        vecs[10] = '{4'd8,  32'h00000001, 32'h0000001F, 32'h80000000, 33'h0, 4'b1000};
        vecs[11] = '{4'd8,  32'h00000001, 32'h00000021, 32'h00000002, 33'h0, 4'b0000};
        vecs[12] = '{4'd9,  32'h80000000, 32'h00000004, 32'h08000000, 33'h0, 4'b0000};
        vecs[13] = '{4'd10, 32'h80000000, 32'h00000021, 32'hC0000000, 33'h0, 4'b1000};
        vecs[14] = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 33'h0, 4'b0000};
        vecs[15] = '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 33'h0, 4'b0001};
        vecs[16] = '{4'd13, 32'h80000001, 32'h00000000, 32'h80000001, 33'h0, 4'b1000};
        vecs[17] = '{4'd14, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 33'h0, 4'b1000};
        vecs[18] = '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 33'h0, 4'b0001};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid32}, 64'd0);
        chk("rst_y", {32'b0, y32}, 64'd0);
        chk("rst_sum", {31'b0, sum32}, 64'd0);
        chk("rst_flags", {60'b0, flags32}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready32}, 64'd1);
        rst = 1'b1;
        @(negedge clk);

        // back-to-back single-cycle ops
        for (int i = 0; i < NV; i++) begin
            sel32 = vecs[i].sel; a32 = vecs[i].a; b32 = vecs[i].b; in_valid32 = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), {63'b0, in_ready32}, 64'd1);
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), {63'b0, out_valid32}, 64'd1);
            chk($sformatf("v%0d_y", i), {32'b0, y32}, {32'b0, vecs[i].y});
            chk($sformatf("v%0d_sum", i), {31'b0, sum32}, {31'b0, vecs[i].sum});
            chk($sformatf("v%0d_flags", i), {60'b0, flags32}, {60'b0, vecs[i].flg});
        end
        in_valid32 = 1'b0;

        // 8-bit MUL 0x12*0x10 = 0x120, then a held ADD is accepted only afterwards
        @(negedge clk);
        sel8 = 4'd15; a8 = 8'h12; b8 = 8'h10; in_valid8 = 1'b1;
        #1;
        chk("mul8_in_ready_pre", {63'b0, in_ready8}, 64'd1);
        @(negedge clk);
        sel8 = 4'd0; a8 = 8'h03; b8 = 8'h04;
        low_cnt = 0; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid8) begin
                seen = 1'b1;
                break;
            end
            if (!in_ready8) low_cnt++;
            @(negedge clk);
        end
        chk("mul8_done_seen", {63'b0, seen}, 64'd1);
        chk("mul8_busy_cycles", 64'(low_cnt), 64'd8);
        chk("mul8_y", {56'b0, y8}, 64'h20);
        chk("mul8_flags", {60'b0, flags8}, 64'b0010);
        chk("mul8_sum", {55'b0, sum8}, 64'd0);
        chk("mul8_in_ready_post", {63'b0, in_ready8}, 64'd1);
        @(negedge clk);
        in_valid8 = 1'b0;
        chk("mul8_next_y", {56'b0, y8}, 64'h07);
        chk("mul8_next_valid", {63'b0, out_valid8}, 64'd1);

        // 32-bit MUL 0xFFFF*0xFFFF = 0xFFFE0001
        sel32 = 4'd15; a32 = 32'h0000FFFF; b32 = 32'h0000FFFF; in_valid32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        low_cnt = 0; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid32) begin
                seen = 1'b1;
                break;
            end
            if (!in_ready32) low_cnt++;
            @(negedge clk);
        end
        chk("mul32_done_seen", {63'b0, seen}, 64'd1);
        chk("mul32_busy_cycles", 64'(low_cnt), 64'd32);
        chk("mul32_y", {32'b0, y32}, 64'hFFFE0001);
        chk("mul32_flags", {60'b0, flags32}, 64'b1000);

        // backpressure: ADD 1+2 held, XOR waits, then same-edge swap
        sel32 = 4'd0; a32 = 32'd1; b32 = 32'd2; in_valid32 = 1'b1; out_ready32 = 1'b1;
        @(negedge clk);
        sel32 = 4'd4; a32 = 32'hF0; b32 = 32'hFF; out_ready32 = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), {63'b0, out_valid32}, 64'd1);
            chk($sformatf("bp%0d_y", k), {32'b0, y32}, 64'd3);
            chk($sformatf("bp%0d_in_ready", k), {63'b0, in_ready32}, 64'd0);
            @(negedge clk);
            #1;
        end
        out_ready32 = 1'b1;
        #1;
        chk("bp_swap_in_ready", {63'b0, in_ready32}, 64'd1);
        @(negedge clk);
        in_valid32 = 1'b0;
        chk("bp_swap_valid", {63'b0, out_valid32}, 64'd1);
        chk("bp_swap_y", {32'b0, y32}, 64'h0F);
        chk("bp_swap_flags", {60'b0, flags32}, 64'd0);

        // reset in the middle of a 32-bit MUL
        sel32 = 4'd1; a32 = 32'd3; b32 = 32'd5; in_valid32 = 1'b1;
        @(negedge clk);
        sel32 = 4'd15; a32 = 32'h3; b32 = 32'h5;
        @(negedge clk);
        in_valid32 = 1'b0;
        chk("rm_pre_y", {32'b0, y32}, 64'hFFFFFFFE);
        chk("rm_pre_in_ready", {63'b0, in_ready32}, 64'd0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rm_valid", {63'b0, out_valid32}, 64'd0);
        chk("rm_y", {32'b0, y32}, 64'd0);
        chk("rm_sum", {31'b0, sum32}, 64'd0);
        chk("rm_flags", {60'b0, flags32}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        ov_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid32) ov_cnt++;
        end
        chk("rm_no_stale_result", 64'(ov_cnt), 64'd0);
        chk("rm_in_ready", {63'b0, in_ready32}, 64'd1);
        sel32 = 4'd0; a32 = 32'd2; b32 = 32'd2; in_valid32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        chk("rm_add_valid", {63'b0, out_valid32}, 64'd1);
        chk("rm_add_y", {32'b0, y32}, 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
